// File: rtl/packet_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : packet_rr_arbiter_if
//  Description : Request/grant bundle between the input ports of one switch
//                output and its packet arbiter.
//                  vld_input_i  [PORT_N] per-port flit valid
//                  last_input_i [PORT_N] per-port tail-flit marker
//                  out_rdy_i             downstream accepts a flit
//                  grant_o      [PORT_N] one-hot grant, zero when idle
//                  mux_in_sel_o [SEL_W]  granted port index, zero when idle
//                  grant_vld_o           a grant is held
//                  xfer_o                a flit moves this cycle
//                master : the request side, which drives the inputs
//                slave  : the arbiter
//  Revision    : 1.0  initial release
// ============================================================================
interface packet_rr_arbiter_if #(
    parameter int PORT_N = 5
);
    localparam int SEL_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

    logic [PORT_N-1:0] vld_input_i;
    logic [PORT_N-1:0] last_input_i;
    logic              out_rdy_i;
    logic [PORT_N-1:0] grant_o;
    logic [SEL_W-1:0]  mux_in_sel_o;
    logic              grant_vld_o;
    logic              xfer_o;

    modport master (
        output vld_input_i, last_input_i, out_rdy_i,
        input  grant_o, mux_in_sel_o, grant_vld_o, xfer_o
    );

    modport slave (
        input  vld_input_i, last_input_i, out_rdy_i,
        output grant_o, mux_in_sel_o, grant_vld_o, xfer_o
    );
endinterface
`default_nettype wire

// File: rtl/packet_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : packet_rr_arbiter
//  Description : Packet-granular output-port arbiter. From IDLE it picks one
//                valid input (fixed priority, highest index wins, or
//                round-robin from a rotating pointer) and holds that grant
//                until the flagged tail flit has transferred. One idle cycle
//                always separates consecutive packets.
//  Ports       : clk_i   clock
//                rst_ni  asynchronous active-low reset
//                bus     packet_rr_arbiter_if.slave (valid/last/ready in,
//                        grant/select/grant_vld/xfer out)
//  Revision    : 1.0  initial release
// ============================================================================
module packet_rr_arbiter #(
    parameter int PORT_N = 5,
    parameter bit RR_EN  = 1'b1
) (
    input  wire logic            clk_i,
    input  wire logic            rst_ni,
    packet_rr_arbiter_if.slave   bus
);
    localparam int SEL_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;
    localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(PORT_N - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    logic [PORT_N-1:0] r_grant;
    logic [SEL_W-1:0]  r_sel;
    logic              r_grant_vld;
    logic [SEL_W-1:0]  r_ptr;

    logic [SEL_W-1:0]  w_win;
    logic              w_any_vld;
    logic              w_xfer;
    logic              w_release;
    logic [SEL_W-1:0]  w_ptr_next;

    assign w_any_vld = |bus.vld_input_i;

    generate
        if (RR_EN) begin : g_rr
            logic [SEL_W:0] w_sum;
            logic [SEL_W:0] w_idx;

            // Scan offsets from farthest to nearest so the last hit is the
            // first valid port at or after the pointer. The sum is one bit
            // wider than the select and folded against PORT_N, which keeps
            // the wrap correct for non-power-of-two port counts.
            always_comb begin
                w_win = '0;
                w_sum = '0;
                w_idx = '0;
                for (int k = PORT_N - 1; k >= 0; k--) begin
                    w_sum = {1'b0, r_ptr} + (SEL_W+1)'(k);
                    if (w_sum >= (SEL_W+1)'(PORT_N)) begin
                        w_idx = w_sum - (SEL_W+1)'(PORT_N);
                    end else begin
                        w_idx = w_sum;
                    end
                    if (bus.vld_input_i[w_idx[SEL_W-1:0]]) begin
                        w_win = w_idx[SEL_W-1:0];
                    end
                end
            end
        end else begin : g_fixed
            // Pointer is held at zero and never consulted in this mode.
            logic w_unused_ptr;
            assign w_unused_ptr = ^r_ptr;

            // Ascending scan: the highest valid index is the last to hit.
            always_comb begin
                w_win = '0;
                for (int i = 0; i < PORT_N; i++) begin
                    if (bus.vld_input_i[i]) begin
                        w_win = SEL_W'(i);
                    end
                end
            end
        end
    endgenerate

    assign w_ptr_next = (w_win == c_last_idx) ? '0 : w_win + SEL_W'(1);

    // r_sel is zero while idle, so gating with r_grant_vld keeps xfer low.
    assign w_xfer    = r_grant_vld & bus.vld_input_i[r_sel] & bus.out_rdy_i;
    assign w_release = w_xfer & bus.last_input_i[r_sel];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_sel       <= '0;
            r_grant_vld <= 1'b0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_vld) begin
                        r_state     <= LOCKED;
                        r_grant     <= PORT_N'(1) << w_win;
                        r_sel       <= w_win;
                        r_grant_vld <= 1'b1;
                        if (RR_EN) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end
                LOCKED: begin
                    // Only the owner's tail transfer ends the packet; other
                    // requesters cannot preempt.
                    if (w_release) begin
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_sel       <= '0;
                        r_grant_vld <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_grant     <= '0;
                    r_sel       <= '0;
                    r_grant_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_o      = r_grant;
    assign bus.mux_in_sel_o = r_sel;
    assign bus.grant_vld_o  = r_grant_vld;
    assign bus.xfer_o       = w_xfer;

endmodule
`default_nettype wire
